skinny_sbox_layer_ctrl: RTL

//  Sequences one full Skinny-64 S-box layer (16 nibbles, two Boolean shares) through a single

---
 rtl/skinny_sbox_layer_ctrl_if.sv | 34 +++
 rtl/skinny_sbox_layer_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/skinny_sbox_layer_ctrl_if.sv
// Bus bundle between the Skinny-64 S-box layer controller, the round-state logic,
// the PRNG and the shared masked S-box instance.
interface skinny_sbox_layer_ctrl_if #(
    parameter int NIBBLES = 16,
    parameter int RND_W   = 21
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NIBBLES-1:0]   in_s0;
    logic [4*NIBBLES-1:0]   in_s1;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*NIBBLES-1:0]   out_s0;
    logic [4*NIBBLES-1:0]   out_s1;
    logic [RND_W-1:0]       rnd_in;
    logic                   rnd_valid;
    logic                   rnd_req;
    logic                   err;
    logic [3:0]             sbox_x_s0;
    logic [3:0]             sbox_x_s1;
    logic [RND_W-1:0]       sbox_fresh;
    logic [3:0]             sbox_y_s0;
    logic [3:0]             sbox_y_s1;

    modport master (
        input  in_valid, in_s0, in_s1, out_ready, rnd_in, rnd_valid, sbox_y_s0, sbox_y_s1,
        output in_ready, out_valid, out_s0, out_s1, rnd_req, err, sbox_x_s0, sbox_x_s1, sbox_fresh
    );

    modport slave (
        output in_valid, in_s0, in_s1, out_ready, rnd_in, rnd_valid, sbox_y_s0, sbox_y_s1,
        input  in_ready, out_valid, out_s0, out_s1, rnd_req, err, sbox_x_s0, sbox_x_s1, sbox_fresh
    );
endinterface

// File: rtl/skinny_sbox_layer_ctrl.sv
// Serialises one two-share Skinny-64 state through a shared free-running masked S-box,
// one nibble per cycle, and reassembles the shared result behind a valid/ready handshake.
module skinny_sbox_layer_ctrl #(
    parameter int LATENCY = 9,
    parameter int NIBBLES = 16,
    parameter int RND_W   = 21
) (
    input  logic                      clk,
    input  logic                      rst_n,
    skinny_sbox_layer_ctrl_if.master  bus
);

    localparam int W  = 4 * NIBBLES;
    localparam int FW = $clog2(LATENCY + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FEED  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

    localparam logic [4:0]    LAST_NIB   = 5'(NIBBLES);
    localparam logic [4:0]    LAST_CAP   = 5'(NIBBLES - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(LATENCY - 1);

    logic [2:0]         state;
    logic [W-1:0]       feed_s0;
    logic [W-1:0]       feed_s1;
    logic [W-1:0]       res_s0;
    logic [W-1:0]       res_s1;
    logic [3:0]         x_s0;
    logic [3:0]         x_s1;
    logic               issue_valid;
    logic [LATENCY-1:0] tag_pipe;
    logic [4:0]         issue_cnt;
    logic [4:0]         cap_cnt;
    logic [FW-1:0]      flush_cnt;
    logic               err_q;

    logic busy;
    logic starve;
    logic capture;

    assign busy    = (state == ST_FEED) || (state == ST_DRAIN);
    assign starve  = busy && !bus.rnd_valid;
    assign capture = busy && tag_pipe[LATENCY-1];

    // The tag pipe mirrors the S-box register depth; its exit marks a valid result nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            feed_s0     <= '0;
            feed_s1     <= '0;
            res_s0      <= '0;
            res_s1      <= '0;
            x_s0        <= '0;
            x_s1        <= '0;
            issue_valid <= 1'b0;
            tag_pipe    <= '0;
            issue_cnt   <= '0;
            cap_cnt     <= '0;
            flush_cnt   <= '0;
            err_q       <= 1'b0;
        end else begin
            if (starve) begin
                tag_pipe <= '0;
            end else begin
                tag_pipe <= {tag_pipe[LATENCY-2:0], issue_valid};
            end

            if (capture && !starve) begin
                res_s0  <= {bus.sbox_y_s0, res_s0[W-1:4]};
                res_s1  <= {bus.sbox_y_s1, res_s1[W-1:4]};
                cap_cnt <= cap_cnt + 5'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        x_s0        <= bus.in_s0[3:0];
                        x_s1        <= bus.in_s1[3:0];
                        feed_s0     <= bus.in_s0 >> 4;
                        feed_s1     <= bus.in_s1 >> 4;
                        issue_valid <= 1'b1;
                        issue_cnt   <= 5'd1;
                        cap_cnt     <= '0;
                        err_q       <= 1'b0;
                        state       <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (starve) begin
                        x_s0        <= '0;
                        x_s1        <= '0;
                        issue_valid <= 1'b0;
                        flush_cnt   <= '0;
                        err_q       <= 1'b1;
                        state       <= ST_FLUSH;
                    end else if (issue_cnt == LAST_NIB) begin
                        x_s0        <= '0;
                        x_s1        <= '0;
                        issue_valid <= 1'b0;
                        state       <= ST_DRAIN;
                    end else begin
                        x_s0      <= feed_s0[3:0];
                        x_s1      <= feed_s1[3:0];
                        feed_s0   <= feed_s0 >> 4;
                        feed_s1   <= feed_s1 >> 4;
                        issue_cnt <= issue_cnt + 5'd1;
                    end
                end
                ST_DRAIN: begin
                    if (starve) begin
                        flush_cnt <= '0;
                        err_q     <= 1'b1;
                        state     <= ST_FLUSH;
                    end else if (capture && cap_cnt == LAST_CAP) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    // Let every stale share drain out of the S-box before a new layer may start.
                    if (flush_cnt == FLUSH_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state == ST_IDLE);
    assign bus.out_valid  = (state == ST_DONE);
    assign bus.out_s0     = res_s0;
    assign bus.out_s1     = res_s1;
    assign bus.rnd_req    = busy || (state == ST_FLUSH) || issue_valid || (|tag_pipe);
    assign bus.err        = err_q;
    assign bus.sbox_x_s0  = x_s0;
    assign bus.sbox_x_s1  = x_s1;
    assign bus.sbox_fresh = bus.rnd_in;

endmodule
